// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the RV32 core: bubble encoding, PC-source codes
// and the fetch FSM state type (also used by hazard_unit and decode).
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [1:0]  PCSRC_SEQ   = 2'b00;
    localparam logic [1:0]  PCSRC_REDIR = 2'b11;

    typedef enum logic [1:0] {
        S_REQ   = 2'b00,
        S_WAIT  = 2'b01,
        S_HOLD  = 2'b10,
        S_DRAIN = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: reset > flush (bubble) > stall (hold) > load.
// A load without a valid instruction inserts a bubble and keeps the PC fields.
module if_id_reg #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_flush,
    input  logic            i_stall,
    input  logic            i_load_valid,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc_plus4,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_valid
);

    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_plus4;
    logic            r_valid;

    // IF/ID state; bubbles leave PCD/PCPlus4D untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= {XLEN{1'b0}};
            r_pc_plus4 <= {XLEN{1'b0}};
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
        end else if (!i_stall) begin
            if (i_load_valid) begin
                r_instr    <= i_instr;
                r_pc       <= i_pc;
                r_pc_plus4 <= i_pc_plus4;
                r_valid    <= 1'b1;
            end else begin
                r_instr    <= NOP_INSTR;
                r_valid    <= 1'b0;
            end
        end else begin
            r_valid    <= r_valid;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PCF, single-outstanding request FSM to a variable-latency
// instruction memory, one-entry holding buffer, and the IF/ID register.
module fetch_stage #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = {XLEN{1'b0}},
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic [1:0]      PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemReady,
    input  logic            ImemValid,
    input  logic [31:0]     ImemRdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic            FetchBusy
);
    import pipeline_pkg::*;

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pcf;
    logic [31:0]     r_buf;

    logic            w_req;
    logic            w_deliverable;
    logic            w_draining;
    logic            w_redirect;
    logic            w_accept;
    logic            w_deliver;
    logic            w_capture;
    logic [31:0]     w_instr;
    logic [XLEN-1:0] w_pc_plus4;

    assign w_redirect = (PCSrcE == PCSRC_REDIR);
    assign w_accept   = w_req && ImemReady;
    assign w_deliver  = w_deliverable && !StallD && !StallF && !w_redirect;
    assign w_capture  = (r_state == S_WAIT) && ImemValid && !w_redirect && !w_deliver;
    assign w_instr    = (r_state == S_HOLD) ? r_buf : ImemRdata;
    assign w_pc_plus4 = r_pcf + XLEN'(4);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; a redirect kills whatever is in flight
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_REQ: begin
                if (w_accept) begin
                    w_state_next = w_redirect ? S_DRAIN : S_WAIT;
                end else begin
                    w_state_next = S_REQ;
                end
            end
            S_WAIT: begin
                if (w_redirect) begin
                    w_state_next = ImemValid ? S_REQ : S_DRAIN;
                end else if (ImemValid) begin
                    w_state_next = w_deliver ? S_REQ : S_HOLD;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_HOLD: begin
                if (w_redirect || w_deliver) begin
                    w_state_next = S_REQ;
                end else begin
                    w_state_next = S_HOLD;
                end
            end
            S_DRAIN: begin
                // the killed response retires the drain even under a new redirect,
                // otherwise the FSM would wait for data the memory never sends
                w_state_next = ImemValid ? S_REQ : S_DRAIN;
            end
            default: w_state_next = S_REQ;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        w_req         = 1'b0;
        w_deliverable = 1'b0;
        w_draining    = 1'b0;
        case (r_state)
            S_REQ:   w_req         = !StallF;
            S_WAIT:  w_deliverable = ImemValid;
            S_HOLD:  w_deliverable = 1'b1;
            S_DRAIN: w_draining    = 1'b1;
            default: w_req         = 1'b0;
        endcase
    end

    // PCF: redirect beats sequential advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcf <= RESET_PC;
        end else if (w_redirect) begin
            r_pcf <= PCTargetE;
        end else if (w_deliver) begin
            r_pcf <= w_pc_plus4;
        end else begin
            r_pcf <= r_pcf;
        end
    end

    // holding buffer for a response that arrived while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf <= NOP_INSTR;
        end else if (w_capture) begin
            r_buf <= ImemRdata;
        end else begin
            r_buf <= r_buf;
        end
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk          (clk),
        .reset        (reset),
        .i_flush      (FlushD),
        .i_stall      (StallD),
        .i_load_valid (w_deliver),
        .i_instr      (w_instr),
        .i_pc         (r_pcf),
        .i_pc_plus4   (w_pc_plus4),
        .o_instr      (InstrD),
        .o_pc         (PCD),
        .o_pc_plus4   (PCPlus4D),
        .o_valid      (ValidD)
    );

    assign ImemReq   = w_req;
    assign ImemAddr  = r_pcf;
    assign FetchBusy = !w_deliverable || w_draining;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level model of the fetch
// stage and a variable-latency instruction memory.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD;
    logic [1:0]  PCSrcE;
    logic [31:0] PCTargetE;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady, ImemValid;
    logic [31:0] ImemRdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, FetchBusy;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemReady(ImemReady), .ImemValid(ImemValid), .ImemRdata(ImemRdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .FetchBusy(FetchBusy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: which request (if any) is in flight, whether it was killed, the held word,
    // and the architectural IF/ID contents.
    bit          m_out, m_kill, m_hold, m_valid;
    logic [31:0] m_pc, m_hbuf, m_instr, m_pcd, m_pc4;
    bit          mem_pend;
    int          mem_wait;
    logic [31:0] mem_addr;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16]} | 32'h0000_0003;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_out = 1'b0; m_kill = 1'b0; m_hold = 1'b0; m_hbuf = NOP;
        m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    endtask

    task automatic check_regs(input string pfx);
        check({pfx, "InstrD"},   InstrD,          m_instr);
        check({pfx, "PCD"},      PCD,             m_pcd);
        check({pfx, "PCPlus4D"}, PCPlus4D,        m_pc4);
        check({pfx, "ValidD"},   32'(ValidD),     32'(m_valid));
        check({pfx, "ImemAddr"}, ImemAddr,        m_pc);
    endtask

    // One clock: drive at negedge, check #1 later, then advance model and memory
    task automatic cycle(input bit sf, input bit sd, input bit fl, input bit rd,
                         input logic [31:0] tgt, input bit rdy, input int lat);
        bit          req, dl, dv;
        logic [31:0] di, pc0;
        @(negedge clk);
        StallF = sf; StallD = sd; FlushD = fl;
        PCSrcE = rd ? 2'b11 : 2'($urandom_range(0, 2));
        PCTargetE = tgt; ImemReady = rdy;
        ImemValid = mem_pend && (mem_wait == 0);
        ImemRdata = ImemValid ? word_at(mem_addr) : $urandom;
        #1;
        pc0 = m_pc;
        req = !m_out && !m_kill && !m_hold && !sf;
        dl  = m_hold || (m_out && ImemValid);
        di  = m_hold ? m_hbuf : ImemRdata;
        check("ImemReq",   32'(ImemReq),   32'(req));
        check("FetchBusy", 32'(FetchBusy), 32'(!dl || m_kill));
        check_regs("");
        dv = dl && !sd && !sf && !rd;
        if (fl) begin
            m_instr = NOP; m_valid = 1'b0;
        end else if (!sd) begin
            if (dv) begin
                m_instr = di; m_pcd = pc0; m_pc4 = pc0 + 32'd4; m_valid = 1'b1;
            end else begin
                m_instr = NOP; m_valid = 1'b0;
            end
        end
        if (m_kill && ImemValid) m_kill = 1'b0;
        if (rd) begin
            if (m_out && !ImemValid) m_kill = 1'b1;
            m_out = 1'b0; m_hold = 1'b0;
            if (req && rdy) m_kill = 1'b1;
            m_pc = tgt;
        end else begin
            if (dv) begin
                m_pc = pc0 + 32'd4; m_hold = 1'b0; m_out = 1'b0;
            end else if (m_out && ImemValid) begin
                m_hold = 1'b1; m_hbuf = ImemRdata; m_out = 1'b0;
            end
            if (req && rdy) m_out = 1'b1;
        end
        if (ImemValid) mem_pend = 1'b0;
        else if (mem_pend && mem_wait > 0) mem_wait--;
        if (req && rdy) begin
            mem_pend = 1'b1; mem_addr = pc0; mem_wait = lat - 1;
        end
    endtask

    task automatic go(input int n, input int lat);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, lat);
    endtask

    initial begin
        bit found;
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 2'b00;
        PCTargetE = 32'h0; ImemReady = 1'b0; ImemValid = 1'b0; ImemRdata = 32'h0;
        model_reset(); mem_pend = 1'b0; mem_wait = 0; mem_addr = 32'h0;
        #12;
        check_regs("rst_");
        check("rst_ImemReq",   32'(ImemReq),   32'd1);
        check("rst_FetchBusy", 32'(FetchBusy), 32'd1);
        @(negedge clk) reset = 1'b0;

        go(8, 1);                                                   // back-to-back fetch
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        go(6, 1);                                                   // stall across response
        go(1, 3);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 3);            // redirect in S_WAIT
        go(10, 2);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1);
        go(4, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1);      // PC wraps through zero
        go(8, 1);

        for (int i = 0; i < 3000; i++) begin
            automatic int  p  = (i / 500) % 3;
            automatic bit  sf = ($urandom_range(0, 99) < (p == 0 ? 10 : 30));
            automatic bit  sd = ($urandom_range(0, 99) < (p == 1 ? 35 : 15));
            automatic bit  fl = ($urandom_range(0, 99) < 8);
            automatic bit  rd = ($urandom_range(0, 99) < (p == 2 ? 15 : 5));
            automatic logic [31:0] tg = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                                        : ($urandom & 32'hFFFF_FFFC);
            cycle(sf, sd, fl, rd, tg, ($urandom_range(0, 99) < 70), $urandom_range(1, 3));
        end

        found = 1'b0;                                               // async reset mid-wait
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3);
            found = m_out && mem_pend && (mem_wait > 0);
        end
        check("found_wait", 32'(found), 32'd1);
        @(posedge clk); #2;
        StallF = 1'b1; ImemReady = 1'b0; ImemValid = 1'b0; reset = 1'b1;
        #1;
        model_reset();
        check_regs("arst_");
        check("arst_FetchBusy", 32'(FetchBusy), 32'd1);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 6 && mem_pend; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        check("stale_drained", 32'(mem_pend), 32'd0);
        go(8, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
